// File: rtl/truth_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package truth_sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  localparam int N_IN    = 3;
  localparam int TABLE_W = 8;

  // Combination 0 lands in the MSB of the table word.
  function automatic logic [N_IN-1:0] tt_bit(input logic [N_IN-1:0] combo);
    return N_IN'(TABLE_W - 1 - int'(combo));
  endfunction

endpackage

// File: rtl/maj3_voter.sv
// Three-deep sample shift register with a 2-of-3 majority output.
module maj3_voter (
  input  logic clk,
  input  logic rst,
  input  logic i_shift,
  input  logic i_bit,
  output logic o_maj
);

  logic [2:0] r_samp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp <= '0;
    end else if (i_shift) begin
      r_samp <= {r_samp[1:0], i_bit};
    end
  end

  assign o_maj = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through 000..111, captures its truth table and compares to EXPECTED.
// Optional majority-of-3 sampling per combination: define TRUTH_SWEEP_VOTE_EN.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned  SETTLE_CYCLES = 4,
  parameter logic [7:0]   EXPECTED      = 8'h64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  state_t              r_state;
  logic [N_IN-1:0]     r_combo;
  logic [CW-1:0]       r_cnt;
  logic [N_IN-1:0]     r_in;
  logic                r_busy;
  logic                r_done;
  logic                r_match;
  logic [TABLE_W-1:0]  r_table;
  logic [TABLE_W-1:0]  w_table;

`ifdef TRUTH_SWEEP_VOTE_EN
  logic [1:0]          r_scnt;
  logic                r_commit;
  logic [N_IN-1:0]     r_cidx;
  logic                w_maj;

  maj3_voter u_voter (
    .clk     (clk),
    .rst     (rst),
    .i_shift (r_state == SAMPLE),
    .i_bit   (dut_out),
    .o_maj   (w_maj)
  );

  // The voted bit is committed one cycle after the last sample; FINISH sees it via w_table.
  always_comb begin
    w_table = r_table;
    if (r_commit) w_table[r_cidx] = w_maj;
  end
`else
  always_comb begin
    w_table = r_table;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_combo <= '0;
      r_cnt   <= '0;
      r_in    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_table <= '0;
`ifdef TRUTH_SWEEP_VOTE_EN
      r_scnt   <= '0;
      r_commit <= 1'b0;
      r_cidx   <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_table <= w_table;
`ifdef TRUTH_SWEEP_VOTE_EN
      r_commit <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !r_done) begin
            r_state <= DRIVE;
            r_combo <= '0;
            r_cnt   <= '0;
            r_table <= '0;
            r_match <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        DRIVE: begin
          r_in  <= r_combo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= SAMPLE;
`ifdef TRUTH_SWEEP_VOTE_EN
            r_scnt  <= '0;
`endif
          end
        end
        SAMPLE: begin
`ifdef TRUTH_SWEEP_VOTE_EN
          r_scnt <= r_scnt + 2'd1;
          if (r_scnt == 2'd2) begin
            r_commit <= 1'b1;
            r_cidx   <= tt_bit(r_combo);
            if (r_combo == N_IN'(TABLE_W - 1)) begin
              r_state <= FINISH;
            end else begin
              r_combo <= r_combo + N_IN'(1);
              r_cnt   <= '0;
              r_state <= DRIVE;
            end
          end
`else
          r_table[tt_bit(r_combo)] <= dut_out;
          if (r_combo == N_IN'(TABLE_W - 1)) begin
            r_state <= FINISH;
          end else begin
            r_combo <= r_combo + N_IN'(1);
            r_cnt   <= '0;
            r_state <= DRIVE;
          end
`endif
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_match <= (w_table == EXPECTED);
          r_busy  <= 1'b0;
          r_in    <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {in1, in2, in3} = r_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign match     = r_match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper with a behavioural gate and table model.
module tb_truth_table_sweeper;

  localparam int         S   = 4;
  localparam logic [7:0] EXP = 8'h64;
`ifdef TRUTH_SWEEP_VOTE_EN
  localparam int PER = S + 3;
`else
  localparam int PER = S + 1;
`endif
  localparam int LAT = 8 * PER + 1;

  logic       clk = 1'b0;
  logic       rst, start, dut_out;
  logic       in1, in2, in3, busy, done, match;
  logic [7:0] table_out;
  logic [7:0] gate_word;
  logic       glitch;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Gate under test: truth word whose MSB is the output for combination 000.
  function automatic logic gate_eval(input logic [7:0] w, input int combo);
    return w[7 - combo];
  endfunction

  function automatic logic [7:0] expected_table(input logic [7:0] w);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[7 - i] = gate_eval(w, i);
    return t;
  endfunction

  assign dut_out = gate_eval(gate_word, int'({in1, in2, in3})) ^ glitch;

  truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .match     (match)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One sweep: pulse start, follow it for LAT+20 cycles. rp* re-pulse start after
  // those cycle numbers; the glitch flips dut_out for the edge after glitch_after.
  task automatic run_sweep(input logic [7:0] gw, input int glitch_after,
                           input int rp0, input int rp1, input int rp2,
                           input bit chk_in, input string tag);
    int n, ndone, first_done;
    logic [7:0] et;
    logic [2:0] ein;
    gate_word  = gw;
    et         = expected_table(gw);
    start      = 1'b1;
    tick;
    start      = 1'b0;
    n          = 0;
    ndone      = 0;
    first_done = -1;
    while (n < LAT + 20) begin
      glitch = (n == glitch_after);
      start  = (n == rp0) || (n == rp1) || (n == rp2);
      tick;
      n++;
      glitch = 1'b0;
      start  = 1'b0;
      if (chk_in && n <= LAT) begin
        ein = (n < LAT) ? 3'((n - 1) / PER) : 3'd0;
        total++;
        if ({in1, in2, in3} !== ein || busy !== (n < LAT))
          $display("FAIL %s inputs cycle %0d: in=%b busy=%b, want in=%b busy=%b",
                   tag, n, {in1, in2, in3}, busy, ein, (n < LAT));
        else passed++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) begin
          first_done = n;
          total++;
          if (table_out !== et || match !== (et == EXP))
            $display("FAIL %s result: table=%h match=%b, want table=%h match=%b",
                     tag, table_out, match, et, (et == EXP));
          else passed++;
        end
      end
    end
    total++;
    if (first_done != LAT) $display("FAIL %s latency: got %0d, want %0d", tag, first_done, LAT);
    else passed++;
    total++;
    if (ndone != 1 || busy !== 1'b0)
      $display("FAIL %s done count/idle: dones=%0d busy=%b, want 1/0", tag, ndone, busy);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; gate_word = 8'h00; glitch = 1'b0;
    #12;
    total++;
    if ({in1, in2, in3} !== 3'b000 || busy !== 1'b0 || done !== 1'b0 ||
        table_out !== 8'h00 || match !== 1'b0)
      $display("FAIL reset: in=%b busy=%b done=%b table=%h match=%b, want all 0",
               {in1, in2, in3}, busy, done, table_out, match);
    else passed++;
    @(negedge clk) rst = 1'b0;
    tick; tick;
    total++;
    if (busy !== 1'b0) $display("FAIL idle_no_start: busy=%b, want 0", busy);
    else passed++;
  endtask

  task automatic test_gate_model;
    run_sweep(EXP, -1, -1, -1, -1, 1'b0, "gate64");
  endtask

  task automatic test_tied;
    run_sweep(8'h00, -1, -1, -1, -1, 1'b0, "tied0");
    run_sweep(8'hFF, -1, -1, -1, -1, 1'b0, "tied1");
  endtask

  task automatic test_inputs;
    run_sweep(8'($urandom), -1, -1, -1, -1, 1'b1, "input_seq");
  endtask

  task automatic test_start_ignored;
    run_sweep(EXP, -1, 5, 40, LAT, 1'b0, "restart_ignored");
  endtask

  task automatic test_reset_midsweep;
    gate_word = EXP;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (20) tick;
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || table_out !== 8'h00 || {in1, in2, in3} !== 3'b000 || done !== 1'b0)
      $display("FAIL mid_reset: busy=%b table=%h in=%b done=%b, want 0/00/000/0",
               busy, table_out, {in1, in2, in3}, done);
    else passed++;
    @(negedge clk) rst = 1'b0;
    tick;
    run_sweep(EXP, -1, -1, -1, -1, 1'b1, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      run_sweep(8'($urandom), -1, -1, -1, -1, 1'b0, "random");
    end
  endtask

`ifdef TRUTH_SWEEP_VOTE_EN
  task automatic test_vote_glitch;
    // Glitch lands only on the middle of combination 3's three sample edges.
    run_sweep(EXP, 3 * PER + S + 1, -1, -1, -1, 1'b0, "vote_glitch");
  endtask
`endif

  initial begin
    test_reset;
    test_gate_model;
    test_tied;
    test_inputs;
    test_start_ignored;
    test_reset_midsweep;
    test_random;
`ifdef TRUTH_SWEEP_VOTE_EN
    test_vote_glitch;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
